// File: rtl/mult_control_unit_if.sv
// Handshake and status bundle between the multiplier controller and its
// requester/datapath. The controller side uses the slave modport.
interface mult_control_unit_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic             r1_gt_r2;
  logic             r1_zero;
  logic             Enable3;
  logic             Enable7;
  logic             Enable9;
  logic             Enable10;
  logic             busy;
  logic             done;
  logic             timeout_err;
  logic [CNT_W-1:0] iter_count;

  modport master (
    output start, r1_gt_r2, r1_zero,
    input  Enable3, Enable7, Enable9, Enable10, busy, done, timeout_err, iter_count
  );

  modport slave (
    input  start, r1_gt_r2, r1_zero,
    output Enable3, Enable7, Enable9, Enable10, busy, done, timeout_err, iter_count
  );
endinterface

// File: rtl/mult_control_unit.sv
// Sequencer for the repeated-addition multiplier datapath: load, optional
// operand swap, bounded accumulate loop, result transfer, done pulse.
//
// state  | meaning
// IDLE   | waiting for start
// LOAD   | Enable3: load operands, clear accumulator and result flag
// CMP    | flags settle on loaded registers, pick swap or loop
// SWAP   | Enable7: put the smaller operand in R1
// LOOP   | Enable10 while R1 != 0 and iteration limit not reached
// FINISH | Enable9: transfer R3 to R4
// DONE   | one-cycle done pulse
module mult_control_unit #(
  parameter int CNT_W    = 16,
  parameter int MAX_ITER = 65535
) (
  input  logic                clk,
  input  logic                rst_n,
  mult_control_unit_if.slave  bus
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_ITER);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    CMP    = 3'd2,
    SWAP   = 3'd3,
    LOOP   = 3'd4,
    FINISH = 3'd5,
    DONE   = 3'd6
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] iter_q, iter_d;
  logic             timeout_q, timeout_d;
  logic             at_limit;

  assign at_limit = (iter_q == MAX_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      iter_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      iter_q    <= iter_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    iter_d    = iter_q;
    timeout_d = timeout_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d   = LOAD;
          iter_d    = '0;
          timeout_d = 1'b0;
        end
      end
      LOAD:   state_d = CMP;
      CMP:    state_d = bus.r1_gt_r2 ? SWAP : LOOP;
      SWAP:   state_d = LOOP;
      LOOP: begin
        // the limit check keeps a stuck r1_zero from spinning forever
        if (bus.r1_zero) begin
          state_d = FINISH;
        end else if (at_limit) begin
          state_d   = FINISH;
          timeout_d = 1'b1;
        end else begin
          iter_d = iter_q + CNT_W'(1);
        end
      end
      FINISH: state_d = DONE;
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.Enable3     = 1'b0;
    bus.Enable7     = 1'b0;
    bus.Enable9     = 1'b0;
    bus.Enable10    = 1'b0;
    bus.done        = 1'b0;
    bus.busy        = (state_q != IDLE);
    bus.timeout_err = timeout_q;
    bus.iter_count  = iter_q;
    case (state_q)
      LOAD:   bus.Enable3  = 1'b1;
      SWAP:   bus.Enable7  = 1'b1;
      LOOP:   bus.Enable10 = ~bus.r1_zero & ~at_limit;
      FINISH: bus.Enable9  = 1'b1;
      DONE:   bus.done     = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mult_control_unit.sv
// Bench for mult_control_unit: datapath model drives the flags, a scoreboard
// checks every completed multiply, a second small-limit instance covers timeout.
module tb_mult_control_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mult_control_unit_if #(.CNT_W(16)) bus ();
  mult_control_unit_if #(.CNT_W(16)) bus_to ();

  mult_control_unit #(.CNT_W(16), .MAX_ITER(65535)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  mult_control_unit #(.CNT_W(16), .MAX_ITER(4)) dut_to (
    .clk(clk), .rst_n(rst_n), .bus(bus_to)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // datapath model
  logic [15:0] dp_in1 = '0, dp_in2 = '0;
  logic [15:0] R1 = '0, R2 = '0;
  logic [31:0] R3 = '0, R4 = '0;

  always @(posedge clk) begin
    if (bus.Enable3) begin
      R1 <= dp_in1; R2 <= dp_in2; R3 <= '0;
    end else if (bus.Enable7) begin
      R1 <= R2; R2 <= R1;
    end else if (bus.Enable10) begin
      R3 <= R3 + 32'(R2); R1 <= R1 - 16'd1;
    end else if (bus.Enable9) begin
      R4 <= R3;
    end
  end

  assign bus.r1_gt_r2    = (R1 > R2);
  assign bus.r1_zero     = (R1 == 16'd0);
  assign bus_to.r1_gt_r2 = 1'b0;
  assign bus_to.r1_zero  = 1'b0;

  typedef struct {
    longint prod;
    int     n;
    int     swp;
    int     lat;
  } exp_t;

  exp_t exp_q[$];

  function automatic exp_t ref_model(input int a, input int b);
    exp_t e;
    e.prod = longint'(a) * longint'(b);
    e.n    = (a < b) ? a : b;
    e.swp  = (a > b) ? 1 : 0;
    e.lat  = e.n + 4 + e.swp;   // LOAD-visible cycle to done-visible cycle
    return e;
  endfunction

  // scoreboard monitor
  bit in_op = 0;
  bit hold_chk = 0;
  int load_cyc = 0;
  int done_cyc = -100;
  int e7 = 0, e9 = 0, e10 = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_op = 0;
    end else begin
      chk("onehot", $countones({bus.Enable3, bus.Enable7, bus.Enable9, bus.Enable10}) > 1, 0);
      if (bus.Enable3) begin
        if (in_op) chk("extra_load", 1, 0);
        if (hold_chk) begin
          chk("restart_gap", cyc - done_cyc, 2);
          hold_chk = 0;
        end
        in_op = 1; load_cyc = cyc; e7 = 0; e9 = 0; e10 = 0;
      end else if (in_op) begin
        e7  += int'(bus.Enable7);
        e9  += int'(bus.Enable9);
        e10 += int'(bus.Enable10);
      end
      if (bus.done) begin
        if (!in_op || exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("product_R4", longint'(R4), e.prod);
          chk("iter_count", longint'(bus.iter_count), e.n);
          chk("enable10_cycles", e10, e.n);
          chk("enable7_cycles", e7, e.swp);
          chk("enable9_cycles", e9, 1);
          chk("latency", cyc - load_cyc, e.lat);
          chk("timeout_err", bus.timeout_err, 0);
          chk("busy_at_done", bus.busy, 1);
        end
        in_op = 0;
        done_cyc = cyc;
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 400; i++) begin
      if (!bus.busy) return;
      @(negedge clk);
    end
    chk("wait_idle_timeout", 1, 0);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus.done) return;
    end
    chk("wait_done_timeout", 1, 0);
  endtask

  task automatic run_op(input int a, input int b, input bit tog);
    int n;
    wait_idle();
    @(negedge clk);
    dp_in1 = 16'(a); dp_in2 = 16'(b);
    bus.start = 1'b1;
    exp_q.push_back(ref_model(a, b));
    @(negedge clk);
    bus.start = 1'b0;
    if (tog) begin
      n = (a < b) ? a : b;
      repeat (n + 2) begin
        @(negedge clk);
        bus.start = 1'($urandom_range(0, 1));
      end
      bus.start = 1'b0;
    end
    wait_done();
  endtask

  initial begin
    int cnt9, cnt10;
    bus.start = 1'b0;
    bus_to.start = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_enables", {bus.Enable3, bus.Enable7, bus.Enable9, bus.Enable10}, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_iter", bus.iter_count, 0);
    chk("rst_timeout", bus.timeout_err, 0);
    chk("rst_to_busy", bus_to.busy, 0);
    rst_n = 1'b1;

    run_op(3, 5, 0);
    run_op(7, 2, 0);
    run_op(0, 9, 0);
    run_op(0, 0, 0);
    run_op(6, 6, 1);

    // asynchronous reset during LOOP
    wait_idle();
    @(negedge clk);
    dp_in1 = 16'd10; dp_in2 = 16'd20;
    bus.start = 1'b1;
    exp_q.push_back(ref_model(10, 20));
    @(negedge clk);
    bus.start = 1'b0;
    repeat (6) @(negedge clk);
    chk("loop_active", bus.Enable10, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_enables", {bus.Enable3, bus.Enable7, bus.Enable9, bus.Enable10}, 0);
    chk("async_rst_busy", bus.busy, 0);
    chk("async_rst_done", bus.done, 0);
    chk("async_rst_iter", bus.iter_count, 0);
    void'(exp_q.pop_back());
    @(negedge clk);
    #2 rst_n = 1'b1;
    run_op(10, 20, 0);

    for (int i = 0; i < 20; i++)
      run_op($urandom_range(0, 12), $urandom_range(0, 12), 1'($urandom_range(0, 1)));

    // start held through DONE restarts two cycles after the done pulse
    wait_idle();
    @(negedge clk);
    dp_in1 = 16'd4; dp_in2 = 16'd6;
    bus.start = 1'b1;
    exp_q.push_back(ref_model(4, 6));
    exp_q.push_back(ref_model(4, 6));
    @(negedge clk);
    #1 hold_chk = 1;
    wait_done();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.Enable3) break;
    end
    bus.start = 1'b0;
    wait_done();
    chk("hold_restart_seen", hold_chk, 0);

    // timeout instance: r1_zero stuck low, limit of 4
    for (int run = 0; run < 2; run++) begin
      @(negedge clk);
      bus_to.start = 1'b1;
      @(negedge clk);
      bus_to.start = 1'b0;
      chk("to_load", bus_to.Enable3, 1);
      chk("to_cleared", bus_to.timeout_err, 0);
      chk("to_iter_cleared", bus_to.iter_count, 0);
      cnt9 = 0; cnt10 = 0;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        chk("to_onehot", $countones({bus_to.Enable3, bus_to.Enable7, bus_to.Enable9, bus_to.Enable10}) > 1, 0);
        cnt9  += int'(bus_to.Enable9);
        cnt10 += int'(bus_to.Enable10);
        if (bus_to.done) break;
      end
      chk("to_done", bus_to.done, 1);
      chk("to_enable10", cnt10, 4);
      chk("to_enable9", cnt9, 1);
      chk("to_err_set", bus_to.timeout_err, 1);
      chk("to_iter", bus_to.iter_count, 4);
      @(negedge clk);
      chk("to_idle", bus_to.busy, 0);
      chk("to_err_sticky", bus_to.timeout_err, 1);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mult_control_unit.md
Name: mult_control_unit

Overview:
- Controller FSM that drives the enable inputs of the repeated-addition multiplier datapath. That datapath holds registers R1, R2, R3 and R4 and a flag register R.
- Accepts a start request, sequences the phases load, optional operand swap, accumulate loop and result transfer, then reports done.
- Consumes status flags computed combinationally from the datapath registers.
- Adds an iteration counter and a timeout guard so a corrupted operand cannot hang the system.

Parameters:
- CNT_W, 16, width of the iteration counter.
- MAX_ITER, 65535, accumulate-cycle limit before forced finish with error; must fit in CNT_W bits.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a multiply; sampled only in IDLE.
- r1_gt_r2  input  1  datapath status: R1 > R2 (unsigned).
- r1_zero  input  1  datapath status: R1 == 0.
- Enable3  output  1  datapath load (R1=in1, R2=in2, R3=0, R=0).
- Enable7  output  1  datapath swap R1/R2.
- Enable9  output  1  datapath result transfer (R4=R3, R=1).
- Enable10  output  1  datapath accumulate (R3+=R2, R1-=1).
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when the result is valid in R4.
- timeout_err  output  1  sticky; set when the loop is aborted at MAX_ITER; cleared by the next accepted start.
- iter_count  output  CNT_W  number of Enable10 cycles issued in the current or last operation.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - All Enables, busy, done and timeout_err = 0.
  - iter_count = 0.
  - Reset mid-operation aborts immediately. Enables drop in the same cycle, and the datapath is left untouched.
- States: IDLE, LOAD, CMP, SWAP, LOOP, FINISH, DONE. Binary encoding.
- Exactly one Enable is high in any cycle, or none.
- IDLE:
  - When start=1 at the edge, go to LOAD.
  - Clear iter_count and timeout_err on that edge.
- LOAD: Enable3=1 for exactly one cycle, then go to CMP.
- CMP:
  - No Enable asserted.
  - Flags reflect the loaded registers.
  - If r1_gt_r2=1, go to SWAP; otherwise go to LOOP. This keeps the loop count at min(in1,in2).
- SWAP: Enable7=1 for exactly one cycle, then go to LOOP.
- LOOP (Mealy output):
  - Enable10 = ~r1_zero & (iter_count != MAX_ITER).
  - Each cycle with Enable10=1 increments iter_count.
  - r1_zero=1 → FINISH, with Enable10 low in that cycle.
  - iter_count == MAX_ITER while r1_zero=0 → set timeout_err, go to FINISH.
- FINISH: Enable9=1 for one cycle, then go to DONE.
- DONE: done=1 for one cycle, then go to IDLE.
- start:
  - Ignored while busy.
  - If start is held high through DONE, a new operation begins from IDLE on the following edge. There are no back-to-back restarts from DONE.
- Latency:
  - Start accepted at edge k. LOAD covers cycle k+1, CMP k+2, SWAP (if taken) k+3.
  - LOOP then takes N+1 cycles for N=min(in1,in2), followed by FINISH and then DONE.
  - Total without swap: N+5 cycles from acceptance to done.
- Zero operand: N=0, so LOOP lasts 1 cycle with no Enable10, and the result is 0.
- iter_count holds its value after DONE until the next accepted start. It never wraps, because MAX_ITER caps it.
- Flag inputs are used only in CMP and LOOP; they are don't-care elsewhere.

Test Plan:
- Reset, then start with a bench datapath model, in1=3, in2=5 → no Enable7; Enable10 high 3 consecutive cycles; Enable9 once; done 8 cycles after start acceptance; iter_count=3; model R4=15.
- in1=7, in2=2 → Enable7 one cycle after CMP; 2 Enable10 cycles; done at cycle 8; iter_count=2; R4=14.
- in1=0, in2=9 → zero Enable10 cycles; done 5 cycles after acceptance; R4=0; timeout_err=0.
- MAX_ITER=4 with r1_zero forced 0 → exactly 4 Enable10 cycles, then Enable9 and done; timeout_err=1. The next start clears it.
- rst_n pulsed low during LOOP (in1=10, in2=20) → outputs 0 asynchronously, state IDLE. The next start runs a full operation correctly.
- start toggled while busy → no extra LOAD. start held high through DONE → a second LOAD 2 cycles after the done pulse; Enable one-hot checked every cycle.
